// File: rtl/regfile_param_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-engine state encoding and the address-width helper.
package regfile_param_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    // A depth of one still needs a one-bit address bus.
    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux with optional write forwarding
// and an optional hardwired-zero register 0.
module rf_read_port
    import regfile_param_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = rf_addr_w(DEPTH)
) (
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_mem [DEPTH],
    input  logic              i_wr_vld,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit;

    always_comb begin
        w_hit  = (BYPASS != 0) && i_wr_vld && (i_wr_addr == i_addr);
        o_data = w_hit ? i_wr_data : i_mem[i_addr];
        // Register 0 wins over the forwarded value as well.
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: storage, write decode, NRD read ports and a
// sequenced bulk-clear engine that stalls the write port while sweeping.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = rf_addr_w(DEPTH)
) (
    input  logic                  CLK_i,
    input  logic                  RES_i,
    input  logic                  WRT_EN_i,
    input  logic [AW-1:0]         WRT_DEST_i,
    input  logic [DATA_W-1:0]     WRT_DATA_i,
    output logic                  WRT_RDY_o,
    input  logic                  CLR_i,
    output logic                  BUSY_o,
    input  logic [NRD*AW-1:0]     READ_ADDR_i,
    output logic [NRD*DATA_W-1:0] RD_DATA_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     w_cnt_nxt;
    logic              w_wr_acc;
    logic              w_wr_zero;

    assign w_wr_acc  = WRT_EN_i && WRT_RDY_o;
    assign w_wr_zero = (ZERO_REG != 0) && (WRT_DEST_i == '0);

    always_ff @(posedge CLK_i or posedge RES_i) begin
        if (RES_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        WRT_RDY_o   = 1'b1;
        BUSY_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (CLR_i) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                WRT_RDY_o = 1'b0;
                BUSY_o    = 1'b1;
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // The sweep owns the storage while clearing; writes cannot be accepted then.
    always_ff @(posedge CLK_i or posedge RES_i) begin
        if (RES_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_acc && !w_wr_zero) begin
            r_mem[WRT_DEST_i] <= WRT_DATA_i;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .i_addr    (READ_ADDR_i[k*AW +: AW]),
            .i_mem     (r_mem),
            .i_wr_vld  (w_wr_acc),
            .i_wr_addr (WRT_DEST_i),
            .i_wr_data (WRT_DATA_i),
            .o_data    (RD_DATA_o[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed bypass/zero/clear/reset checks on two small
// configurations and a randomized 4-port run against an array model.
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A: 8x8, two ports, bypass on, no zero register
    logic        a_wen = 0, a_clr = 0, a_rdy, a_busy;
    logic [2:0]  a_wdest = 0;
    logic [7:0]  a_wdata = 0;
    logic [5:0]  a_raddr = 0;
    logic [15:0] a_rdata;

    regfile_param #(.DATA_W(8), .DEPTH(8), .NRD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLK_i(clk), .RES_i(rst), .WRT_EN_i(a_wen), .WRT_DEST_i(a_wdest),
        .WRT_DATA_i(a_wdata), .WRT_RDY_o(a_rdy), .CLR_i(a_clr), .BUSY_o(a_busy),
        .READ_ADDR_i(a_raddr), .RD_DATA_o(a_rdata));

    // B: 8x8, two ports, bypass off, register 0 hardwired to zero
    logic        b_wen = 0, b_clr = 0, b_rdy, b_busy;
    logic [2:0]  b_wdest = 0;
    logic [7:0]  b_wdata = 0;
    logic [5:0]  b_raddr = 0;
    logic [15:0] b_rdata;

    regfile_param #(.DATA_W(8), .DEPTH(8), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK_i(clk), .RES_i(rst), .WRT_EN_i(b_wen), .WRT_DEST_i(b_wdest),
        .WRT_DATA_i(b_wdata), .WRT_RDY_o(b_rdy), .CLR_i(b_clr), .BUSY_o(b_busy),
        .READ_ADDR_i(b_raddr), .RD_DATA_o(b_rdata));

    // C: 32x16, four ports, bypass on
    logic        c_wen = 0, c_clr = 0, c_rdy, c_busy;
    logic [4:0]  c_wdest = 0;
    logic [15:0] c_wdata = 0;
    logic [19:0] c_raddr = 0;
    logic [63:0] c_rdata;

    regfile_param #(.DATA_W(16), .DEPTH(32), .NRD(4), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .CLK_i(clk), .RES_i(rst), .WRT_EN_i(c_wen), .WRT_DEST_i(c_wdest),
        .WRT_DATA_i(c_wdata), .WRT_RDY_o(c_rdy), .CLR_i(c_clr), .BUSY_o(c_busy),
        .READ_ADDR_i(c_raddr), .RD_DATA_o(c_rdata));

    logic [15:0] c_mem [32];
    int          c_sweep;   // next register the model's clear will zero, -1 when idle

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a();
        for (int i = 0; i < 8; i++) begin
            a_wen = 1; a_wdest = 3'(i); a_wdata = 8'(8'h11 * (i + 1));
            next_cycle();
        end
        a_wen = 0;
    endtask

    initial begin
        c_sweep = -1;
        for (int i = 0; i < 32; i++) c_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 0;

        // reset state
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(7 - i), 3'(i)};
            #1;
            check($sformatf("rst_a_p0_%0d", i), a_rdata[7:0], 0);
            check($sformatf("rst_a_p1_%0d", 7 - i), a_rdata[15:8], 0);
        end
        check("rst_rdy", a_rdy, 1);
        check("rst_busy", a_busy, 0);
        check("rst_c_rdy", c_rdy, 1);

        // randomized run on C
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        exp_rdy;
            logic [4:0]  ad;
            logic [15:0] e;
            c_wen   = ($urandom_range(0, 3) != 0);
            c_wdest = 5'($urandom_range(0, 31));
            c_wdata = 16'($urandom);
            c_clr   = ($urandom_range(0, 79) == 0);
            for (int k = 0; k < 4; k++) begin
                c_raddr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? c_wdest : 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            exp_rdy = (c_sweep < 0);
            check("c_rdy", c_rdy, exp_rdy);
            check("c_busy", c_busy, !exp_rdy);
            for (int k = 0; k < 4; k++) begin
                ad = c_raddr[k*5 +: 5];
                e  = c_mem[ad];
                if (exp_rdy && c_wen && c_wdest == ad) e = c_wdata;
                check($sformatf("c_rd%0d_cyc%0d", k, cyc), c_rdata[k*16 +: 16], e);
            end
            @(posedge clk);
            if (c_sweep >= 0) begin
                c_mem[c_sweep] = '0;
                c_sweep = (c_sweep == 31) ? -1 : c_sweep + 1;
            end else begin
                if (c_wen) c_mem[c_wdest] = c_wdata;
                if (c_clr) c_sweep = 0;
            end
            #1;
        end
        c_wen = 0; c_clr = 0;
        repeat (34) next_cycle();

        // B: no bypass, write visible one cycle later
        b_wen = 1; b_wdest = 3; b_wdata = 8'hA5; b_raddr = {3'd3, 3'd3};
        @(negedge clk);
        check("b_nobyp_same", b_rdata[7:0], 8'h00);
        next_cycle();
        b_wen = 0;
        #1;
        check("b_nobyp_next", b_rdata[7:0], 8'hA5);
        check("b_nobyp_p1", b_rdata[15:8], 8'hA5);

        // B: register 0 discards writes and never forwards
        b_wen = 1; b_wdest = 0; b_wdata = 8'hFF; b_raddr = {3'd3, 3'd0};
        @(negedge clk);
        check("b_zero_same", b_rdata[7:0], 8'h00);
        next_cycle();
        b_wen = 0;
        #1;
        check("b_zero_next", b_rdata[7:0], 8'h00);
        next_cycle();
        check("b_zero_later", b_rdata[7:0], 8'h00);

        // A: bypass
        a_wen = 1; a_wdest = 3; a_wdata = 8'hA5; a_raddr = {3'd2, 3'd3};
        @(negedge clk);
        check("a_byp_same", a_rdata[7:0], 8'hA5);
        check("a_byp_other", a_rdata[15:8], 8'h00);
        next_cycle();
        a_wen = 0;
        #1;
        check("a_byp_next", a_rdata[7:0], 8'hA5);

        // A: full clear sweep with a dropped write in the middle
        fill_a();
        a_raddr = {3'd0, 3'd5};
        #1;
        check("a_fill_r5", a_rdata[7:0], 8'h66);
        check("a_fill_r0", a_rdata[15:8], 8'h11);
        a_clr = 1;
        next_cycle();
        a_clr = 0;
        for (int k = 1; k <= 8; k++) begin
            a_wen = (k == 4); a_wdest = 0; a_wdata = 8'hEE; a_raddr = {3'd0, 3'd5};
            @(negedge clk);
            check($sformatf("clr_busy_%0d", k), a_busy, 1);
            check($sformatf("clr_rdy_%0d", k), a_rdy, 0);
            check($sformatf("clr_r5_%0d", k), a_rdata[7:0], (k <= 6) ? 8'h66 : 8'h00);
            check($sformatf("clr_r0_%0d", k), a_rdata[15:8], (k == 1) ? 8'h11 : 8'h00);
            next_cycle();
        end
        a_wen = 0;
        check("clr_done_busy", a_busy, 0);
        check("clr_done_rdy", a_rdy, 1);
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(i), 3'(i)};
            #1;
            check($sformatf("clr_done_r%0d", i), a_rdata[7:0], 0);
        end

        // A: reset in the middle of a clear
        fill_a();
        a_clr = 1;
        next_cycle();
        a_clr = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #1;
        check("midrst_busy", a_busy, 0);
        check("midrst_rdy", a_rdy, 1);
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(i), 3'(i)};
            #1;
            check($sformatf("midrst_r%0d", i), a_rdata[7:0], 0);
        end
        next_cycle();
        rst = 0;
        a_wen = 1; a_wdest = 6; a_wdata = 8'h3C; a_raddr = {3'd6, 3'd6};
        @(negedge clk);
        check("post_rst_byp", a_rdata[15:8], 8'h3C);
        next_cycle();
        a_wen = 0;
        #1;
        check("post_rst_read", a_rdata[7:0], 8'h3C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
